ntt_stage_ctrl: RTL and testbench

- Sequencer for the in-place radix-2 NTT/INTT over one N=256-coefficient polynomial (12-bit coefficients, q=3329). Kyber-style: 7 butterfly stages, 128 butterflies per stage, with Cooley-Tukey for NTT and Gentleman-Sande for INTT.
- Each cycle it issues one butterfly's read-address pair and twiddle index.
- It delays the write-back address pair by the butterfly pipeline latency, so results land in place.
- Between stages it stalls until the pipeline drains, which removes read-after-write hazards.

---
 rtl/ntt_pkg.sv | 49 ++++
 rtl/ntt_stage_ctrl_if.sv | 30 +++
 rtl/shift_n.sv | 25 ++
 rtl/ntt_stage_ctrl.sv | 127 ++++++++++++
 tb/tb_ntt_stage_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and butterfly address helper for the NTT/INTT stage sequencer.
package ntt_pkg;

  localparam int unsigned N_LOG   = 8;
  localparam int unsigned STAGES  = 7;
  localparam int unsigned BF_LAT  = 7;
  localparam int unsigned ADDR_W  = N_LOG;
  localparam int unsigned TW_W    = STAGES;
  localparam int unsigned J_W     = N_LOG - 1;
  localparam int unsigned STAGE_W = $clog2(STAGES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addrA;
    logic [ADDR_W-1:0] addrB;
    logic [TW_W-1:0]   tw;
  } beat_t;

  // CT halves the butterfly span each stage, GS doubles it; both reduce to len = 1 << sh.
  function automatic beat_t calcBeat(input logic mode,
                                     input logic [STAGE_W-1:0] stage,
                                     input logic [J_W-1:0] j);
    int unsigned sh;
    int unsigned len;
    int unsigned g;
    int unsigned k;
    int unsigned base;
    int unsigned tw;
    beat_t beat;
    sh   = mode ? (32'(stage) + 32'd1) : ((N_LOG - 32'd1) - 32'(stage));
    len  = 32'd1 << sh;
    g    = 32'(j) >> sh;
    k    = 32'(j) & (len - 32'd1);
    base = (g << (sh + 32'd1)) + k;
    tw   = mode ? ((32'd1 << (STAGES - 32'(stage))) - 32'd1 - g)
                : ((32'd1 << stage) + g);
    beat.addrA = ADDR_W'(base);
    beat.addrB = ADDR_W'(base + len);
    beat.tw    = TW_W'(tw);
    return beat;
  endfunction

endpackage

// File: rtl/ntt_stage_ctrl_if.sv
// Control/address bundle between the stage sequencer and its coefficient RAM / butterfly datapath.
interface ntt_stage_ctrl_if;
  import ntt_pkg::*;

  logic              start;
  logic              mode;
  logic              busy;
  logic              done;
  logic              bf_mode;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [TW_W-1:0]   tw_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [ADDR_W-1:0] wr_addr_b;

  modport master (
    output start, mode,
    input  busy, done, bf_mode, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input  wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start, mode,
    output busy, done, bf_mode, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b
  );

endinterface

// File: rtl/shift_n.sv
// Fixed-depth delay line; reset clears every tap so nothing stale emerges afterwards.
module shift_n #(
  parameter int unsigned data_width = 1,
  parameter int unsigned depth      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] i_data,
  output logic [data_width-1:0] o_data
);

  logic [data_width-1:0] r_pipe [depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < depth; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[depth-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// In-place radix-2 NTT/INTT sequencer: one butterfly read per cycle, write-back delayed by the
// butterfly latency, and a drain gap between stages so no stage reads a coefficient still in flight.
module ntt_stage_ctrl
  import ntt_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  ntt_stage_ctrl_if.slave bus
);

  localparam int unsigned D_W    = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int unsigned PIPE_W = 1 + 2 * ADDR_W;

  state_t               r_state;
  state_t               w_nextState;
  logic                 r_mode;
  logic                 w_nextMode;
  logic [STAGE_W-1:0]   r_stage;
  logic [STAGE_W-1:0]   w_nextStage;
  logic [J_W-1:0]       r_j;
  logic [J_W-1:0]       w_nextJ;
  logic [D_W-1:0]       r_d;
  logic [D_W-1:0]       w_nextD;
  logic                 r_rdEn;
  logic                 r_busy;
  logic                 r_done;
  beat_t                r_beat;
  logic [PIPE_W-1:0]    w_wrPipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_stage <= '0;
      r_j     <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_nextState;
      r_mode  <= w_nextMode;
      r_stage <= w_nextStage;
      r_j     <= w_nextJ;
      r_d     <= w_nextD;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextMode  = r_mode;
    w_nextStage = r_stage;
    w_nextJ     = r_j;
    w_nextD     = r_d;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_nextState = RUN;
          w_nextMode  = bus.mode;
          w_nextStage = '0;
          w_nextJ     = '0;
        end
      end
      RUN: begin
        w_nextJ = r_j + 1'b1;
        if (&r_j) begin
          w_nextState = DRAIN;
          w_nextD     = '0;
        end
      end
      DRAIN: begin
        w_nextD = r_d + 1'b1;
        // Last write-back of this stage lands now; next stage may read from the following cycle.
        if (r_d == D_W'(BF_LAT - 1)) begin
          w_nextD = '0;
          if (r_stage < STAGE_W'(STAGES - 1)) begin
            w_nextState = RUN;
            w_nextStage = r_stage + 1'b1;
            w_nextJ     = '0;
          end else begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdEn <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_beat <= '0;
    end else begin
      r_rdEn <= (w_nextState == RUN);
      r_busy <= (w_nextState == RUN) || (w_nextState == DRAIN);
      r_done <= (w_nextState == DONE);
      r_beat <= (w_nextState == RUN) ? calcBeat(w_nextMode, w_nextStage, w_nextJ) : '0;
    end
  end

  shift_n #(
    .data_width(PIPE_W),
    .depth     (BF_LAT)
  ) u_wrDelay (
    .clk   (clk),
    .rst   (rst),
    .i_data({r_rdEn, r_beat.addrA, r_beat.addrB}),
    .o_data(w_wrPipe)
  );

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.bf_mode   = r_mode;
  assign bus.rd_en     = r_rdEn;
  assign bus.rd_addr_a = r_beat.addrA;
  assign bus.rd_addr_b = r_beat.addrB;
  assign bus.tw_addr   = r_beat.tw;
  assign bus.wr_en     = w_wrPipe[PIPE_W-1];
  assign bus.wr_addr_a = w_wrPipe[2*ADDR_W-1 -: ADDR_W];
  assign bus.wr_addr_b = w_wrPipe[ADDR_W-1:0];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Self-checking bench for ntt_stage_ctrl: a cycle-timeline reference model built from stage timing
// and span/group arithmetic, randomized start/mode noise, chained transforms and a mid-run reset.
module tb_ntt_stage_ctrl;

  localparam int LAT       = 7;
  localparam int STAGE_LEN = 128 + LAT;
  localparam int DONE_T    = 7 * STAGE_LEN + 1;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ntt_stage_ctrl_if bus ();

  ntt_stage_ctrl u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expected);
    checks++;
    if (obs !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expected);
    end
  endtask

  function automatic logic [63:0] obsAll();
    return 64'({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.bf_mode,
                bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b});
  endfunction

  function automatic logic [63:0] obsCtl();
    return 64'({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.bf_mode});
  endfunction

  function automatic logic [63:0] obsRd();
    return 64'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr});
  endfunction

  // Which butterfly (stage*128 + j) is read at cycle t after start acceptance, or -1.
  function automatic int readSlot(input int t);
    int base;
    for (int s = 0; s < 7; s++) begin
      base = 1 + s * STAGE_LEN;
      if (t >= base && t <= base + 127) return s * 128 + (t - base);
    end
    return -1;
  endfunction

  function automatic logic [22:0] expBeat(input int s, input int j, input logic m);
    int len;
    int g;
    int k;
    int a;
    int tw;
    if (!m) len = 128 / (2 ** s);
    else    len = 2 * (2 ** s);
    g  = j / len;
    k  = j % len;
    a  = g * 2 * len + k;
    tw = m ? (2 ** (7 - s) - 1 - g) : (2 ** s + g);
    return {8'(a), 8'(a + len), 7'(tw)};
  endfunction

  // Called at a negedge with the DUT idle; start is accepted at the next posedge (cycle 0).
  task automatic applyStimulus(input logic m, input int abortAt);
    int          rdCount = 0;
    int          wrCount = 0;
    int          bad = 0;
    int          slot;
    int          wslot;
    int          wrHits[256];
    int          rdStarts[$];
    int          wrEnds[$];
    logic        prevRd = 1'b0;
    logic        prevWr = 1'b0;
    logic [4:0]  expCtl;
    logic [22:0] eb;
    for (int i = 0; i < 256; i++) wrHits[i] = 0;
    bus.start = 1'b1;
    bus.mode  = m;
    for (int t = 1; t <= DONE_T; t++) begin
      @(negedge clk);
      slot   = readSlot(t);
      wslot  = readSlot(t - LAT);
      expCtl = {(t <= DONE_T - 1), (t == DONE_T), (slot >= 0), (wslot >= 0), m};
      checkOutput($sformatf("ctl t=%0d m=%0d", t, m), obsCtl(), 64'(expCtl));
      if (slot >= 0) begin
        eb = expBeat(slot / 128, slot % 128, m);
        checkOutput($sformatf("rd t=%0d m=%0d", t, m), obsRd(), 64'(eb));
      end
      if (wslot >= 0) begin
        eb = expBeat(wslot / 128, wslot % 128, m);
        checkOutput($sformatf("wr t=%0d m=%0d", t, m), 64'({bus.wr_addr_a, bus.wr_addr_b}), 64'(eb[22:7]));
      end
      if (!m && t == 1)   checkOutput("ntt first beat", obsRd(), 64'({8'd0, 8'd128, 7'd1}));
      if (!m && t == 2)   checkOutput("ntt second beat", obsRd(), 64'({8'd1, 8'd129, 7'd1}));
      if (!m && t == 7)   checkOutput("ntt no wr at 7", 64'(bus.wr_en), 64'd0);
      if (!m && t == 8)   checkOutput("ntt first wr", 64'({bus.wr_en, bus.wr_addr_a, bus.wr_addr_b}), 64'({1'b1, 8'd0, 8'd128}));
      if (!m && t == 136) checkOutput("ntt s1 first", obsRd(), 64'({8'd0, 8'd64, 7'd2}));
      if (!m && t == 200) checkOutput("ntt s1 j64", obsRd(), 64'({8'd128, 8'd192, 7'd3}));
      if (!m && t == 938) checkOutput("ntt s6 last", obsRd(), 64'({8'd253, 8'd255, 7'd127}));
      if (m && t == 1)    checkOutput("intt first beat", obsRd(), 64'({8'd0, 8'd2, 7'd127}));
      if (m && t == 811)  checkOutput("intt s6 first", obsRd(), 64'({8'd0, 8'd128, 7'd1}));
      if (t == 946)       checkOutput("done@946", 64'({bus.done, bus.busy}), 64'({1'b1, 1'b0}));
      if (bus.rd_en) rdCount++;
      if (bus.wr_en) begin
        wrCount++;
        wrHits[bus.wr_addr_a]++;
        wrHits[bus.wr_addr_b]++;
      end
      if (bus.rd_en && !prevRd) rdStarts.push_back(t);
      if (!bus.wr_en && prevWr) wrEnds.push_back(t - 1);
      prevRd = bus.rd_en;
      prevWr = bus.wr_en;
      if (t == abortAt) begin
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        checkOutput("abort outputs zero", obsAll(), 64'd0);
        return;
      end
      bus.start = (t == DONE_T) || ($urandom_range(0, 7) == 0);
      bus.mode  = 1'($urandom);
    end
    @(negedge clk);
    checkOutput($sformatf("idle after done m=%0d", m), obsCtl(), 64'({4'b0000, m}));
    checkOutput("rd count", 64'(rdCount), 64'd896);
    checkOutput("wr count", 64'(wrCount), 64'd896);
    for (int i = 0; i < 256; i++) if (wrHits[i] != 7) bad++;
    checkOutput("addrs not written 7x", 64'(bad), 64'd0);
    checkOutput("rd runs", 64'(rdStarts.size()), 64'd7);
    checkOutput("wr runs", 64'(wrEnds.size()), 64'd7);
    if (rdStarts.size() == 7 && wrEnds.size() == 7) begin
      for (int s = 1; s < 7; s++)
        checkOutput($sformatf("hazard gap s=%0d", s), 64'(rdStarts[s]), 64'(wrEnds[s-1] + 1));
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset state", obsAll(), 64'd0);
    rst = 1'b0;

    // Chained transforms: each start is held through the done cycle and accepted one cycle later.
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 0);
    applyStimulus(1'($urandom), 0);
    applyStimulus(1'($urandom), 0);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);

    applyStimulus(1'b0, 300);
    repeat (2) begin
      @(negedge clk);
      checkOutput("held reset zero", obsAll(), 64'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post reset quiet %0d", i), obsCtl(), 64'd0);
    end

    applyStimulus(1'b0, 0);
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("final idle", obsCtl(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
